display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Double-buffered BCD load, dead-time gating, leading-zero blanking.
module display_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_value,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        frame_end,
  output logic        bcd_err
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

  localparam logic [0:0] S_DEAD = 1'b0;
  localparam logic [0:0] S_ON   = 1'b1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [15:0]   disp;
  logic [15:0]   disp_nxt;
  logic [15:0]   pend;
  logic          pend_valid;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [3:0]    nibble_q;
  logic [3:0]    nibble_nxt;
  logic          bcd_err_q;
  logic          tick;
  logic          accept;
  logic          bcd_ok;
  logic          swap;
  logic [3:0]    blank;

  // Slot timing, handshake and next-state terms.
  always_comb begin
    tick       = (cnt == CNT_MAX);
    frame_end  = tick && (idx == 2'd3);
    load_ready = ~pend_valid;
    accept     = load_valid && load_ready;
    bcd_ok     = (load_value[3:0]   <= 4'd9) &&
                 (load_value[7:4]   <= 4'd9) &&
                 (load_value[11:8]  <= 4'd9) &&
                 (load_value[15:12] <= 4'd9);
    swap       = frame_end && pend_valid;
    cnt_nxt    = tick ? '0 : cnt + 1'b1;
    idx_nxt    = tick ? idx + 2'd1 : idx;
    disp_nxt   = swap ? pend : disp;
    state_nxt  = (cnt_nxt < DEAD_C) ? S_DEAD : S_ON;
  end

  // Nibble for the digit that will be scanned next cycle.
  always_comb begin
    nibble_nxt = disp_nxt[3:0];
    unique case (idx_nxt)
      2'd0: nibble_nxt = disp_nxt[3:0];
      2'd1: nibble_nxt = disp_nxt[7:4];
      2'd2: nibble_nxt = disp_nxt[11:8];
      2'd3: nibble_nxt = disp_nxt[15:12];
    endcase
  end

  // Leading-zero blanking; units digit always lights.
  always_comb begin
    blank[0] = 1'b0;
    blank[1] = blank_lz && (disp[15:4]  == 12'h000);
    blank[2] = blank_lz && (disp[15:8]  == 8'h00);
    blank[3] = blank_lz && (disp[15:12] == 4'h0);
  end

  // Active-low anode drive: dark in dead time or when blanked.
  always_comb begin
    an = 4'b1111;
    if (state == S_ON && !blank[idx])
      an = ~(4'b0001 << idx);
  end

  // Scan counters, display/pending buffers and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_valid <= 1'b0;
      state      <= S_DEAD;
      nibble_q   <= 4'h0;
      bcd_err_q  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      disp      <= disp_nxt;
      state     <= state_nxt;
      nibble_q  <= nibble_nxt;
      bcd_err_q <= accept && !bcd_ok;
      if (accept && bcd_ok) begin
        pend       <= load_value;
        pend_valid <= 1'b1;
      end else if (swap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign nibble  = nibble_q;
  assign bcd_err = bcd_err_q;

endmodule
